interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Collects interrupt raise lines from bus peripherals (timer, mouse, etc.) and presents one
//  interrupt at a time to the CPU. Latches requests as pending, applies a CPU-writable mask, and
//  arbitrates by fixed priority. Returns the CPU acknowledge to the granted source only.
//  Sits between peripheral BUS_INTERRUPT_RAISE/ACK pins and the CPU interrupt inputs.
// PARAMETERS
//  BaseAddr      8'hE8  memory-map base address; occupies BaseAddr+0..+3
//  NumSources    4      number of peripheral interrupt lines (1..8)
//  InitialMask   8'hFF  reset value of mask register; bit i = 1 enables source i
// PORTS
//  CLK                  in   1     system clock, single clock domain
//  RST                  in   1     synchronous, active-high reset
//  BUS_ADDR             in   8     shared bus address
//  BUS_DATA             inout 8    shared bus data; tristated unless this block is read
//  BUS_WE               in   1     bus write enable
//  SRC_INTERRUPT_RAISE  in   NumSources  per-source raise level (held until acked)
//  SRC_INTERRUPT_ACK    out  NumSources  per-source one-cycle ack pulse
//  CPU_INTERRUPT_RAISE  out  1     interrupt request to CPU
//  CPU_INTERRUPT_ACK    in   1     CPU acknowledge (one-cycle pulse)
//  CPU_INTERRUPT_ID     out  3     index of the source currently raised to CPU
// BEHAVIOUR
//  Register map: +0 pending (R), +1 mask (R/W), +2 pending clear (W, write-1-to-clear),
//   +3 active id (R, bit7 = request in flight, bits2:0 = id). Unused bits read 0.
//  Reset: pending=0, mask=InitialMask[NumSources-1:0], src_q=0, state=IDLE,
//   CPU_INTERRUPT_RAISE=0, CPU_INTERRUPT_ID=0, SRC_INTERRUPT_ACK=0, BUS_DATA=Z.
//  Edge capture: src_q <= SRC_INTERRUPT_RAISE every cycle; pending[i] set at edge where
//   SRC[i] & ~src_q[i]. Source high when RST releases counts as a new edge.
//  Pending set and clear (write-clear or ack) on same edge for the same bit: set wins.
//  FSM:
//   IDLE:  if (pending & mask) != 0, latch lowest set index into active, RAISE=1 -> GRANT.
//   GRANT: RAISE held 1, ID = active.
//          CPU_INTERRUPT_ACK -> SRC_INTERRUPT_ACK[active] pulses 1 cycle, pending[active]
//            cleared, RAISE=0 -> HOLDOFF.
//          mask[active] cleared or pending[active] cleared by bus write (no ack) -> RAISE=0,
//            pending kept per write, no SRC ack -> IDLE.
//   HOLDOFF: one cycle, RAISE=0, lets source drop its line -> IDLE.
//  Latency: source rises sampled at edge k -> pending at k -> RAISE high after edge k+1.
//   CPU ack at edge m -> SRC ack high and RAISE low after edge m; next grant no earlier than m+2.
//  Higher-priority arrival during GRANT does not pre-empt; it is served after HOLDOFF.
//  CPU_INTERRUPT_ACK outside GRANT is ignored.
//  Reads: address match with BUS_WE=0 captured at edge n; BUS_DATA driven with value captured
//   at edge n during cycle n..n+1 only; Z otherwise. Writes take effect at the edge sampled.
//  RST mid-GRANT: RAISE drops next edge, no SRC ack issued, all pending lost.
// TESTING
//  1 Reset, raise SRC[0] -> pending=0x01 after 1 edge, RAISE=1, ID=0 one edge later.
//  2 SRC[2] and SRC[1] same cycle, mask=0x0F -> ID=1 granted; ack -> SRC_ACK=0b0010 one cycle,
//    HOLDOFF, then ID=2 granted; ack -> SRC_ACK=0b0100; pending=0.
//  3 mask=0x0E, raise SRC[0] -> no RAISE, read +0 returns 0x01; write mask 0x0F -> RAISE=1 ID=0.
//  4 In GRANT ID=3, write 0x08 to +2 -> RAISE=0 next edge, no SRC_ACK, state IDLE, pending=0.
//  5 Read +1 after reset -> BUS_DATA=0x0F next cycle, Z cycle after; write cycles keep BUS_DATA Z.
//  6 Assert RST during GRANT -> RAISE=0, SRC_ACK never pulses, pending=0, mask=0x0F.

Source files
------------

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Latches peripheral interrupt edges as pending, masks them, and
//               presents the lowest-index request to the CPU one at a time.
// Revision    : 1.0
// ============================================================================
module interrupt_controller #(
  parameter logic [7:0] BaseAddr    = 8'hE8,
  parameter int         NumSources  = 4,
  parameter logic [7:0] InitialMask = 8'hFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            BUS_ADDR,
  inout  wire  [7:0]            BUS_DATA,
  input  logic                  BUS_WE,
  input  logic [NumSources-1:0] SRC_INTERRUPT_RAISE,
  output logic [NumSources-1:0] SRC_INTERRUPT_ACK,
  output logic                  CPU_INTERRUPT_RAISE,
  input  logic                  CPU_INTERRUPT_ACK,
  output logic [2:0]            CPU_INTERRUPT_ID
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                  state;
  logic [NumSources-1:0]   src_q;
  logic [NumSources-1:0]   pending;
  logic [NumSources-1:0]   mask;
  logic                    rd_en;
  logic [7:0]              rd_data;

  logic [7:0]              offset;
  logic                    sel;
  logic                    wr_mask;
  logic                    wr_clr;
  logic                    ack_take;
  logic                    withdraw;
  logic                    unused_data;
  logic [NumSources-1:0]   rise;
  logic [NumSources-1:0]   active_onehot;
  logic [NumSources-1:0]   clr_bits;
  logic [NumSources-1:0]   pending_nxt;
  logic [NumSources-1:0]   mask_nxt;
  logic [NumSources-1:0]   req;
  logic [2:0]              lowest;
  logic [7:0]              pending_ext;
  logic [7:0]              mask_ext;
  logic [7:0]              rd_val;

  assign offset   = BUS_ADDR - BaseAddr;
  assign sel      = (offset[7:2] == 6'd0);
  assign wr_mask  = sel & BUS_WE & (offset[1:0] == 2'd1);
  assign wr_clr   = sel & BUS_WE & (offset[1:0] == 2'd2);
  assign ack_take = (state == GRANT) & CPU_INTERRUPT_ACK;
  assign rise     = SRC_INTERRUPT_RAISE & ~src_q;
  assign unused_data = ^BUS_DATA;

  always_comb begin
    active_onehot = '0;
    for (int i = 0; i < NumSources; i++) begin
      active_onehot[i] = (CPU_INTERRUPT_ID == 3'(i));
    end
  end

  // A new edge on the same cycle as a clear keeps the bit set.
  always_comb begin
    clr_bits = '0;
    if (wr_clr) begin
      clr_bits = BUS_DATA[NumSources-1:0];
    end
    if (ack_take) begin
      clr_bits = clr_bits | active_onehot;
    end
    pending_nxt = (pending & ~clr_bits) | rise;
  end

  assign mask_nxt = wr_mask ? BUS_DATA[NumSources-1:0] : mask;
  assign req      = pending & mask;
  assign withdraw = ~|(active_onehot & pending_nxt & mask_nxt);

  always_comb begin
    lowest = 3'd0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (req[i]) begin
        lowest = 3'(i);
      end
    end
  end

  always_comb begin
    pending_ext                   = 8'h00;
    mask_ext                      = 8'h00;
    pending_ext[NumSources-1:0]   = pending;
    mask_ext[NumSources-1:0]      = mask;
    case (offset[1:0])
      2'd0:    rd_val = pending_ext;
      2'd1:    rd_val = mask_ext;
      2'd3:    rd_val = {CPU_INTERRUPT_RAISE, 4'b0000, CPU_INTERRUPT_ID};
      default: rd_val = 8'h00;
    endcase
  end

  // Read data is captured at the addressing edge and held on the bus for one cycle.
  assign BUS_DATA = rd_en ? rd_data : 8'hzz;

  always_ff @(posedge CLK) begin
    if (RST) begin
      src_q               <= '0;
      pending             <= '0;
      mask                <= InitialMask[NumSources-1:0];
      state               <= IDLE;
      CPU_INTERRUPT_RAISE <= 1'b0;
      CPU_INTERRUPT_ID    <= 3'd0;
      SRC_INTERRUPT_ACK   <= '0;
      rd_en               <= 1'b0;
      rd_data             <= 8'h00;
    end else begin
      src_q             <= SRC_INTERRUPT_RAISE;
      pending           <= pending_nxt;
      mask              <= mask_nxt;
      rd_en             <= sel & ~BUS_WE;
      rd_data           <= rd_val;
      SRC_INTERRUPT_ACK <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            CPU_INTERRUPT_ID    <= lowest;
            CPU_INTERRUPT_RAISE <= 1'b1;
            state               <= GRANT;
          end
        end
        GRANT: begin
          if (CPU_INTERRUPT_ACK) begin
            SRC_INTERRUPT_ACK   <= active_onehot;
            CPU_INTERRUPT_RAISE <= 1'b0;
            state               <= HOLDOFF;
          end else if (withdraw) begin
            CPU_INTERRUPT_RAISE <= 1'b0;
            state               <= IDLE;
          end
        end
        HOLDOFF: begin
          state <= IDLE;
        end
        default: begin
          CPU_INTERRUPT_RAISE <= 1'b0;
          state               <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
